avalon_wait_ram: RTL
====================

Name: avalon_wait_ram

Overview:
- Avalon memory-mapped slave RAM: the responder end of the bus driven by top-level CPU master (address/read/write/writedata/byteenable in; readdata/waitrequest out).
- Word-organised storage with configurable read/write wait states, byte-lane writes and a testbench preload port.
- Sits beside the CPU in every ALU/branch/memory testcase bench; replaces ad-hoc RAM models with cycle-exact, checkable timing.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; byte address space is 0 .. DEPTH_WORDS*4-1
- READ_WAIT, 2, extra stall cycles before a read completes (0 allowed)
- WRITE_WAIT, 1, extra stall cycles before a write completes (0 allowed)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears FSM and outputs, not memory contents
- address  in  32  byte address from master; bits [1:0] ignored
- read  in  1  read request
- write  in  1  write request
- writedata  in  32  write data
- byteenable  in  4  byte-lane enables; bit i covers writedata[8i+7:8i]
- readdata  out  32  read data, registered
- waitrequest  out  1  stall; transfer completes in the cycle where (read|write)=1 and waitrequest=0
- load_en  in  1  preload strobe (bench side)
- load_addr  in  8  preload byte address, word-aligned
- load_data  in  32  preload word
- mem_clear  in  1  synchronous: zero every word in one cycle
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset values: readdata=0, proto_err=0, FSM=IDLE, counter=0. waitrequest is combinational: waitrequest = (read|write) & (state!=ACK), so it is 0 when idle with no request.
- FSM states: IDLE, BUSY, ACK.
- IDLE: on (read|write) & !load_en, latch op and word index, load counter with READ_WAIT or WRITE_WAIT; go to BUSY if the count is >0, else to ACK.
- BUSY: decrement the counter each cycle; enter ACK when it reaches 1. Counter freezes while load_en=1.
- Entry to ACK on a read: readdata <= mem[idx]. readdata holds until the next read completes.
- ACK lasts one cycle with waitrequest=0. On a write, the edge ending ACK writes the bytes whose byteenable bit is set. byteenable=0 completes with no change. Next state is IDLE; a new request cannot be accepted before the following cycle.
- Latency: a request first seen in cycle 0 completes in cycle WAIT+1 (READ_WAIT=2 gives completion in cycle 3).
- Address and data are sampled at acceptance; the master holds them stable per protocol, and later changes are ignored.
- Out of range (address >= DEPTH_WORDS*4): handshake completes normally; read returns 0; write is dropped.
- read & write asserted together: read is performed, write is dropped, proto_err set.
- Request deasserted while in BUSY: FSM returns to IDLE with no side effect; proto_err set.
- Reset mid-transfer: FSM returns to IDLE, the pending write is discarded, readdata=0, memory is untouched.
- load_en: mem[load_addr[7:2]] <= load_data that cycle. It has priority over a bus write to the same word in the same cycle, and blocks acceptance of new requests.
- mem_clear: priority over load_en and bus writes.
- Byte lane 0 = bits [7:0], little lane order. No endian swap; the CPU owns byte ordering.

Decomposition:
- avalon_mem_pkg: state enum (IDLE/BUSY/ACK), WORD_BYTES=4, helper function to convert a byte address to a word index.
- Sub-module byte_lane_merge (old word, new word, byteenable -> merged word), purely combinational, reused by future cache/LSU work.
- FSM, counter and storage stay in the top module.

Test Plan:
- Preload 0x04=0x24030010, 0x08=0x24040020; read 0x04 with READ_WAIT=2 -> waitrequest high cycles 0-2, low cycle 3, readdata=0x24030010.
- Write 0xAABBCCDD to 0x10 with byteenable=4'b0101 over existing 0x11223344 -> later read returns 0x11BB33DD; completion at cycle WRITE_WAIT+1=2.
- Read 0x400 (out of range, DEPTH 256) -> completes at cycle 3 with readdata=0. Write 0x400 -> no word changes; mem_clear then a read of 0x10 -> 0.
- Assert reset in BUSY of a write of 0xFFFFFFFF to 0x20 -> FSM IDLE next cycle, readdata=0, read of 0x20 returns its prior value.
- read=write=1 at 0x08 -> readdata=0x24040020, memory unchanged, proto_err=1 until reset.
- READ_WAIT=0: back-to-back reads 0x04, 0x08 -> each completes one cycle after acceptance, with one IDLE cycle between them.

Source files
------------

// File: rtl/avalon_mem_pkg.sv
// avalon_mem_pkg
//   Shared types and helpers for the Avalon wait-state RAM.
//   - ram_state_t  : bus-side handshake FSM states (IDLE / BUSY / ACK)
//   - WORD_BYTES   : bytes per storage word
//   - CNT_W        : width of the wait-state counter
//   - byte_to_word : byte address -> word index (drops the byte-offset bits)
package avalon_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } ram_state_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 16;

    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return byte_addr >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge
//   Purely combinational byte-lane merge: each byte of the result comes from
//   new_word where its byteenable bit is set, otherwise from old_word.
//   Lane 0 is bits [7:0] (little lane order, no endian swap).
// Ports:
//   old_word    in  32  current stored word
//   new_word    in  32  incoming write data
//   byteenable  in  4   lane select, bit i covers bits [8i+7:8i]
//   merged_word out 32  merged result
module byte_lane_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  byteenable,
    output logic [31:0] merged_word
);

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteenable[i]) begin
                merged_word[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram
//   Avalon-MM slave RAM with configurable read/write wait states, byte-lane
//   writes, a bench-side preload port and a single-cycle clear.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (byte space 0 .. DEPTH_WORDS*4-1)
//   READ_WAIT    stall cycles before a read completes (0 allowed)
//   WRITE_WAIT   stall cycles before a write completes (0 allowed)
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   address/read/write/writedata/byteenable   Avalon request from master
//   readdata                    registered read data
//   waitrequest                 combinational stall
//   load_en/load_addr/load_data preload path (priority over bus writes)
//   mem_clear                   zero all words (priority over everything)
//   proto_err                   sticky protocol-violation flag
module avalon_wait_ram
    import avalon_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int READ_WAIT   = 2,
    parameter int WRITE_WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic        mem_clear,
    output logic        proto_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    ram_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] stall_count;
    logic             op_read, op_read_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             in_range, in_range_next;
    logic [31:0]      wdata_q, wdata_next;
    logic [3:0]       be_q, be_next;
    logic [31:0]      readdata_next;
    logic             proto_err_next;

    logic             req;
    logic [31:0]      addr_word;
    logic             addr_in_range;
    logic [IDX_W-1:0] addr_idx;
    logic [31:0]      load_word;
    logic             load_in_range;
    logic [IDX_W-1:0] load_idx;
    logic [31:0]      cur_word;
    logic [31:0]      merged_word;
    logic             bus_wr;

    assign req           = read | write;
    assign addr_word     = byte_to_word(address);
    assign addr_in_range = addr_word < 32'(DEPTH_WORDS);
    assign addr_idx      = addr_word[IDX_W-1:0];
    assign load_word     = byte_to_word({24'd0, load_addr});
    assign load_in_range = load_word < 32'(DEPTH_WORDS);
    assign load_idx      = load_word[IDX_W-1:0];

    // Stall whenever a request is present and we are not in the single
    // completion cycle.
    assign waitrequest = req & (state != ACK);

    assign cur_word = mem[idx];

    byte_lane_merge u_merge (
        .old_word    (cur_word),
        .new_word    (wdata_q),
        .byteenable  (be_q),
        .merged_word (merged_word)
    );

    // The write lands on the edge that ends ACK; reset in that same cycle
    // discards it.
    assign bus_wr = (state == ACK) && !op_read && in_range && !reset;

    // Next-state logic. readdata is captured on the edge entering ACK so it
    // is valid during the completion cycle. With zero wait states the
    // index comes straight from the bus since nothing is latched yet.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        op_read_next   = op_read;
        idx_next       = idx;
        in_range_next  = in_range;
        wdata_next     = wdata_q;
        be_next        = be_q;
        readdata_next  = readdata;
        proto_err_next = proto_err;
        stall_count    = read ? CNT_W'(READ_WAIT) : CNT_W'(WRITE_WAIT);

        case (state)
            IDLE: begin
                if (req && !load_en) begin
                    op_read_next  = read;
                    idx_next      = addr_idx;
                    in_range_next = addr_in_range;
                    wdata_next    = writedata;
                    be_next       = byteenable;
                    if (read && write) begin
                        proto_err_next = 1'b1;
                    end
                    if (stall_count == '0) begin
                        state_next = ACK;
                        cnt_next   = '0;
                        if (read) begin
                            readdata_next = addr_in_range ? mem[addr_idx] : '0;
                        end
                    end else begin
                        state_next = BUSY;
                        cnt_next   = stall_count;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_next     = IDLE;
                    cnt_next       = '0;
                    proto_err_next = 1'b1;
                end else if (!load_en) begin
                    if (cnt <= CNT_W'(1)) begin
                        state_next = ACK;
                        cnt_next   = '0;
                        if (op_read) begin
                            readdata_next = in_range ? cur_word : '0;
                        end
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_read   <= 1'b0;
            idx       <= '0;
            in_range  <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            readdata  <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            op_read   <= op_read_next;
            idx       <= idx_next;
            in_range  <= in_range_next;
            wdata_q   <= wdata_next;
            be_q      <= be_next;
            readdata  <= readdata_next;
            proto_err <= proto_err_next;
        end
    end

    // Storage is not reset. The preload assignment follows the bus write so
    // it wins when both target the same word in one cycle.
    always_ff @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (bus_wr) begin
                mem[idx] <= merged_word;
            end
            if (load_en && load_in_range) begin
                mem[load_idx] <= load_data;
            end
        end
    end

endmodule
